// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl -- ping-pong scanline buffer for the motion-object path.
//
// The renderer writes pixels into the back bank while the front bank (filled
// during the previous line) is read out one pixel per MCKR rising edge. The
// banks swap on the falling edge of NXL_b as seen on successive pixel ticks.
// Front entries can be cleared behind the read pointer so the next line that
// lands in that bank starts out transparent.
//
// Ports:
//   clk100, rst_b          system clock, async active-low reset
//   MCKR                   pixel clock level, edge-detected in clk100 domain
//   NXL_b                  new-line strobe (active low)
//   HBLANK_b               high during active display
//   BUFCLR_b               low = clear front entry after it is read
//   wr_valid/wr_x/wr_data  renderer write request, accepted with wr_ready
//   pix_out/pix_valid      front-bank pixel and its one-cycle qualifier
//   bank_sel               index of the current front bank
//   drop_err               sticky flag: a write addressed beyond the line
//
// Build option: define LB_PRIORITY_EN for first-write-wins writes (a stored
// pixel with non-zero low nibble is kept); otherwise last-write-wins.

module line_buffer_ctrl #(
  parameter int LINE_W = 336,
  parameter int DW     = 8
) (
  input  logic          clk100,
  input  logic          rst_b,
  input  logic          MCKR,
  input  logic          NXL_b,
  input  logic          HBLANK_b,
  input  logic          BUFCLR_b,
  input  logic          wr_valid,
  input  logic [8:0]    wr_x,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [DW-1:0] pix_out,
  output logic          pix_valid,
  output logic          bank_sel,
  output logic          drop_err
);

  localparam logic [8:0] X_END  = 9'(LINE_W);
  localparam logic [8:0] X_LAST = 9'(LINE_W - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} top_state_e;

  top_state_e    state_q, state_d;
  logic [8:0]    init_x_q, init_x_d;
  logic          init_bank_q, init_bank_d;
  logic          mckr_q;
  logic          nxl_prev_q, nxl_prev_d;
  logic          bank_sel_q, bank_sel_d;
  logic [8:0]    rd_x_q, rd_x_d;
  logic [DW-1:0] pix_out_q, pix_out_d;
  logic          pix_valid_q, pix_valid_d;
  logic          wr_ready_q, wr_ready_d;
  logic          drop_err_q, drop_err_d;
  logic          clr_pend_q, clr_pend_d;
  logic          clr_bank_q, clr_bank_d;
  logic [8:0]    clr_x_q, clr_x_d;

  logic          tick_s, run_s, swap_s, rd_en_s, rd_bank_s;
  logic [8:0]    rd_idx_s, rd_addr_s;
  logic [DW-1:0] rd_data_s;
  logic          wr_acc_s, wr_in_s;
  logic          wp_we_s, wp_bank_s;
  logic [8:0]    wp_x_s;
  logic [DW-1:0] wp_data_s;

  logic [DW-1:0]       mem_bank [2][LINE_W];
  logic [1:0]          mem_we_s;
  logic [1:0][8:0]     mem_x_s;
  logic [1:0][DW-1:0]  mem_wd_s;

  // Tick detection and read/swap decode; a swap tick reads address 0 of the new front bank
  always_comb begin
    tick_s    = ~mckr_q & MCKR;
    run_s     = (state_q == ST_RUN);
    swap_s    = run_s & tick_s & ~NXL_b & nxl_prev_q;
    rd_en_s   = 1'b0;
    rd_bank_s = bank_sel_q;
    rd_idx_s  = rd_x_q;
    if (swap_s) begin
      rd_bank_s = ~bank_sel_q;
      rd_idx_s  = 9'd0;
      rd_en_s   = HBLANK_b;
    end else if (run_s & tick_s & HBLANK_b & (rd_x_q < X_END)) begin
      rd_en_s   = 1'b1;
    end else begin
      rd_en_s   = 1'b0;
    end
    // Saturated pointer never indexes past the bank
    rd_addr_s = (rd_idx_s < X_END) ? rd_idx_s : 9'd0;
    rd_data_s = mem_bank[rd_bank_s][rd_addr_s];
    wr_acc_s  = wr_valid & wr_ready_q;
    wr_in_s   = (wr_x < X_END);
  end

  // Top FSM next state, read pointer, bank select and pixel output
  always_comb begin
    state_d     = state_q;
    init_x_d    = init_x_q;
    init_bank_d = init_bank_q;
    nxl_prev_d  = nxl_prev_q;
    bank_sel_d  = bank_sel_q;
    rd_x_d      = rd_x_q;
    pix_valid_d = rd_en_s;
    clr_pend_d  = rd_en_s & ~BUFCLR_b;
    clr_bank_d  = rd_bank_s;
    clr_x_d     = rd_addr_s;
    case (state_q)
      ST_INIT: begin
        if (init_x_q == X_LAST) begin
          init_x_d = 9'd0;
          if (init_bank_q) begin
            init_bank_d = 1'b0;
            state_d     = ST_RUN;
          end else begin
            init_bank_d = 1'b1;
          end
        end else begin
          init_x_d = init_x_q + 9'd1;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          nxl_prev_d = NXL_b;
        end else begin
          nxl_prev_d = nxl_prev_q;
        end
        if (swap_s) begin
          bank_sel_d = ~bank_sel_q;
          rd_x_d     = {8'd0, HBLANK_b};
        end else if (rd_en_s) begin
          rd_x_d     = rd_x_q + 9'd1;
        end else begin
          rd_x_d     = rd_x_q;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (rd_en_s) begin
      pix_out_d = rd_data_s;
    end else begin
      pix_out_d = pix_out_q;
    end
  end

`ifdef LB_PRIORITY_EN
  typedef enum logic {WR_IDLE = 1'b0, WR_CMP = 1'b1} wr_state_e;

  wr_state_e     wst_q, wst_d;
  logic [8:0]    cmp_x_q, cmp_x_d;
  logic [DW-1:0] cmp_data_q, cmp_data_d;
  logic          cmp_bank_q, cmp_bank_d;
  logic          cmp_ok_q, cmp_ok_d;
  logic [3:0]    cmp_old_q, cmp_old_d;
  logic [8:0]    wr_addr_s;

  // Two-cycle compare-write: sample the stored pixel on accept, commit only over transparent
  always_comb begin
    wst_d      = wst_q;
    cmp_x_d    = cmp_x_q;
    cmp_data_d = cmp_data_q;
    cmp_bank_d = cmp_bank_q;
    cmp_ok_d   = cmp_ok_q;
    cmp_old_d  = cmp_old_q;
    wr_ready_d = run_s;
    drop_err_d = drop_err_q | (wr_acc_s & ~wr_in_s);
    wr_addr_s  = wr_in_s ? wr_x : 9'd0;
    wp_we_s    = 1'b0;
    wp_bank_s  = cmp_bank_q;
    wp_x_s     = cmp_x_q;
    wp_data_s  = cmp_data_q;
    case (wst_q)
      WR_IDLE: begin
        if (wr_acc_s) begin
          wst_d      = WR_CMP;
          cmp_x_d    = wr_addr_s;
          cmp_data_d = wr_data;
          cmp_bank_d = ~bank_sel_q;
          cmp_ok_d   = wr_in_s;
          cmp_old_d  = mem_bank[~bank_sel_q][wr_addr_s][3:0];
          wr_ready_d = 1'b0;
        end else begin
          wst_d      = WR_IDLE;
        end
      end
      WR_CMP: begin
        wst_d   = WR_IDLE;
        wp_we_s = cmp_ok_q & (cmp_old_q == 4'd0);
      end
      default: begin
        wst_d = WR_IDLE;
      end
    endcase
  end

  // Compare-write registers
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      wst_q      <= WR_IDLE;
      cmp_x_q    <= 9'd0;
      cmp_data_q <= '0;
      cmp_bank_q <= 1'b0;
      cmp_ok_q   <= 1'b0;
      cmp_old_q  <= 4'd0;
    end else begin
      wst_q      <= wst_d;
      cmp_x_q    <= cmp_x_d;
      cmp_data_q <= cmp_data_d;
      cmp_bank_q <= cmp_bank_d;
      cmp_ok_q   <= cmp_ok_d;
      cmp_old_q  <= cmp_old_d;
    end
  end
`else
  // Single-cycle last-write-wins port into the bank that is back at acceptance
  always_comb begin
    wr_ready_d = run_s;
    drop_err_d = drop_err_q | (wr_acc_s & ~wr_in_s);
    wp_we_s    = wr_acc_s & wr_in_s;
    wp_bank_s  = ~bank_sel_q;
    wp_x_s     = wr_x;
    wp_data_s  = wr_data;
  end
`endif

  // Per-bank write selection: init fill, renderer write, trailing clear
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      if (state_q == ST_INIT) begin
        mem_we_s[b] = (init_bank_q == 1'(b));
        mem_x_s[b]  = init_x_q;
        mem_wd_s[b] = '0;
      end else if (wp_we_s && (wp_bank_s == 1'(b))) begin
        mem_we_s[b] = 1'b1;
        mem_x_s[b]  = wp_x_s;
        mem_wd_s[b] = wp_data_s;
      end else if (clr_pend_q && (clr_bank_q == 1'(b))) begin
        mem_we_s[b] = 1'b1;
        mem_x_s[b]  = clr_x_q;
        mem_wd_s[b] = '0;
      end else begin
        mem_we_s[b] = 1'b0;
        mem_x_s[b]  = 9'd0;
        mem_wd_s[b] = '0;
      end
    end
  end

  // Bank storage; contents are initialised by the INIT sweep, not by reset
  always_ff @(posedge clk100) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_we_s[b]) begin
        mem_bank[b][mem_x_s[b]] <= mem_wd_s[b];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_INIT;
      init_x_q    <= 9'd0;
      init_bank_q <= 1'b0;
      mckr_q      <= 1'b0;
      nxl_prev_q  <= 1'b1;
      bank_sel_q  <= 1'b0;
      rd_x_q      <= 9'd0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      drop_err_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_bank_q  <= 1'b0;
      clr_x_q     <= 9'd0;
    end else begin
      state_q     <= state_d;
      init_x_q    <= init_x_d;
      init_bank_q <= init_bank_d;
      mckr_q      <= MCKR;
      nxl_prev_q  <= nxl_prev_d;
      bank_sel_q  <= bank_sel_d;
      rd_x_q      <= rd_x_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      wr_ready_q  <= wr_ready_d;
      drop_err_q  <= drop_err_d;
      clr_pend_q  <= clr_pend_d;
      clr_bank_q  <= clr_bank_d;
      clr_x_q     <= clr_x_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign bank_sel  = bank_sel_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl -- directed plus randomized bench for line_buffer_ctrl.
// A line-level model (two pixel arrays, front index, read count) predicts every
// pixel read out on each tick.

module tb_line_buffer_ctrl;

  localparam int LINE_W = 336;
  localparam int INIT_CYCLES = 2 * LINE_W;

  logic       clk100 = 1'b0;
  logic       rst_b, MCKR, NXL_b, HBLANK_b, BUFCLR_b, wr_valid;
  logic [8:0] wr_x;
  logic [7:0] wr_data;
  logic       wr_ready, pix_valid, bank_sel, drop_err;
  logic [7:0] pix_out;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [2][LINE_W];
  int         m_front;
  int         m_rd;
  logic       m_nxl_prev;
  logic       m_drop;

  always #5 clk100 = ~clk100;

  line_buffer_ctrl #(.LINE_W(LINE_W), .DW(8)) dut (
    .clk100   (clk100),
    .rst_b    (rst_b),
    .MCKR     (MCKR),
    .NXL_b    (NXL_b),
    .HBLANK_b (HBLANK_b),
    .BUFCLR_b (BUFCLR_b),
    .wr_valid (wr_valid),
    .wr_x     (wr_x),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .pix_out  (pix_out),
    .pix_valid(pix_valid),
    .bank_sel (bank_sel),
    .drop_err (drop_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < LINE_W; x++) ref_mem[b][x] = 8'h00;
    m_front    = 0;
    m_rd       = 0;
    m_nxl_prev = 1'b1;
    m_drop     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_out"},   {24'd0, pix_out}, 32'd0);
    chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    chk({tag, "_wr_ready"},  {31'd0, wr_ready}, 32'd0);
    chk({tag, "_bank_sel"},  {31'd0, bank_sel}, 32'd0);
    chk({tag, "_drop_err"},  {31'd0, drop_err}, 32'd0);
  endtask

  // Called right after rst_b rises at a falling edge
  task automatic wait_init(input string tag);
    int early = 0;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      @(posedge clk100); #1;
      if (wr_ready !== 1'b0) early++;
    end
    chk({tag, "_ready_low"}, early, 32'd0);
    @(posedge clk100); #1;
    chk({tag, "_ready_high"}, {31'd0, wr_ready}, 32'd1);
  endtask

  // One pixel tick: MCKR low for 3 cycles, then rises with the given controls
  task automatic tick(input logic nxl, input logic hb, input logic clr, output logic [7:0] obs);
    logic       ev;
    logic [7:0] ed;
    MCKR = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    NXL_b = nxl; HBLANK_b = hb; BUFCLR_b = clr; MCKR = 1'b1;
    if (!nxl && m_nxl_prev) begin
      m_front = 1 - m_front;
      m_rd    = 0;
    end
    m_nxl_prev = nxl;
    ev = 1'b0;
    ed = 8'h00;
    if (hb && m_rd < LINE_W) begin
      ev = 1'b1;
      ed = ref_mem[m_front][m_rd];
      if (!clr) ref_mem[m_front][m_rd] = 8'h00;
      m_rd++;
    end
    @(posedge clk100); #1;
    chk("pix_valid", {31'd0, pix_valid}, {31'd0, ev});
    if (ev) chk("pix_out", {24'd0, pix_out}, {24'd0, ed});
    chk("bank_sel", {31'd0, bank_sel}, m_front);
    obs = pix_out;
    @(posedge clk100); #1;
    chk("pix_strobe", {31'd0, pix_valid}, 32'd0);
    repeat (2) @(posedge clk100);
    #1;
  endtask

  task automatic do_write(input logic [8:0] x, input logic [7:0] d);
    int n = 0;
    int b;
    while (wr_ready !== 1'b1 && n < 16) begin
      @(posedge clk100); #1;
      n++;
    end
    chk("wr_ready_wait", {31'd0, (n < 16)}, 32'd1);
    wr_valid = 1'b1; wr_x = x; wr_data = d;
    @(posedge clk100); #1;
    wr_valid = 1'b0;
    b = 1 - m_front;
    if (x >= LINE_W) begin
      m_drop = 1'b1;
    end else begin
`ifdef LB_PRIORITY_EN
      if (ref_mem[b][x][3:0] == 4'h0) ref_mem[b][x] = d;
`else
      ref_mem[b][x] = d;
`endif
    end
    chk("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
`ifdef LB_PRIORITY_EN
    chk("wr_ready_after_accept", {31'd0, wr_ready}, 32'd0);
`endif
  endtask

  initial begin
    logic [7:0] obs;
    logic [7:0] exp9;
    int         sel_before;

    rst_b = 1'b0; MCKR = 1'b0; NXL_b = 1'b1; HBLANK_b = 1'b0; BUFCLR_b = 1'b1;
    wr_valid = 1'b0; wr_x = 9'd0; wr_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk100);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk100);
    rst_b = 1'b1;
    wait_init("init1");

    // Both banks read zero before any write
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, obs);
    for (int i = 0; i < 4; i++) tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);

    // x=5 lands on the sixth pixel after the swap; x=9 exercises double write
    do_write(9'd5, 8'hA3);
    do_write(9'd9, 8'h12);
    do_write(9'd9, 8'h34);
`ifdef LB_PRIORITY_EN
    exp9 = 8'h12;
`else
    exp9 = 8'h34;
`endif
    for (int i = 0; i < 10; i++) begin
      tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);
      if (i == 5)      chk("tp_x5", {24'd0, obs}, 32'hA3);
      else if (i == 9) chk("tp_x9", {24'd0, obs}, {24'd0, exp9});
      else             chk("tp_zero", {24'd0, obs}, 32'h00);
    end

    // Same with clearing, then the bank comes back around transparent
    do_write(9'd5, 8'hA3);
    for (int i = 0; i < 6; i++) begin
      tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, obs);
      if (i == 5) chk("clr_x5_first", {24'd0, obs}, 32'hA3);
    end
    for (int i = 0; i < 3; i++) tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);
    for (int i = 0; i < 6; i++) begin
      tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);
      if (i == 5) chk("clr_x5_again", {24'd0, obs}, 32'h00);
    end

    // Out-of-range write: flagged, banks untouched
    chk("drop_before", {31'd0, drop_err}, 32'd0);
    sel_before = bank_sel;
    do_write(9'd400, 8'h5A);
    chk("drop_after", {31'd0, drop_err}, 32'd1);
    chk("drop_bank_sel", {31'd0, bank_sel}, sel_before);

    // Full line: pointer saturates at LINE_W, later ticks give no pixel
    for (int i = 0; i < LINE_W + 4; i++) tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);

    // Randomized writes and ticks
    for (int it = 0; it < 120; it++) begin
      int nwr;
      nwr = $urandom_range(0, 3);
      for (int w = 0; w < nwr; w++) begin
        logic [8:0] x;
        if ($urandom_range(0, 9) == 0) x = 9'($urandom_range(330, 345));
        else                          x = 9'($urandom_range(0, 15));
        do_write(x, 8'($urandom));
      end
      tick(($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, obs);
    end
    chk("drop_sticky", {31'd0, drop_err}, 32'd1);

    // Reset mid-line after 100 ticks with data in both banks
    do_write(9'd5, 8'h77);
    do_write(9'd0, 8'h11);
    tick(1'b0, 1'b1, 1'b1, obs);
    do_write(9'd5, 8'h66);
    do_write(9'd1, 8'h22);
    for (int i = 0; i < 99; i++) tick(1'b1, 1'b1, 1'b1, obs);
    @(posedge clk100); #3;
    rst_b = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    MCKR = 1'b0;
    model_reset();
    @(negedge clk100);
    rst_b = 1'b1;
    wait_init("init2");
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1, 1'b1, obs);
      chk("post_rst_b0", {24'd0, obs}, 32'h00);
    end
    for (int i = 0; i < 6; i++) begin
      tick((i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, obs);
      chk("post_rst_b1", {24'd0, obs}, 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

- Ping-pong scanline buffer sitting directly downstream of the system clock/timing generator.
- The motion-object renderer writes 8-bit colour indices into the back bank during the current line. The front bank, written during the previous line, is read out one pixel per MCKR period during active display.
- Banks swap on every new-line strobe (NXL_b).
- Front-bank locations are cleared behind the read pointer while BUFCLR_b is low, so the next line starts transparent.

## Interface
Parameters:
- LINE_W, 336: pixels per line; also the depth of each bank.
- DW, 8: pixel width.

Ports:
- clk100  in  1  system clock; all logic on its rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- MCKR  in  1  pixel clock level from the timing generator; sampled in the clk100 domain.
- NXL_b  in  1  new-line strobe, active low.
- HBLANK_b  in  1  high during active display.
- BUFCLR_b  in  1  low = clear front-bank entry after it is read.
- wr_valid  in  1  renderer write request.
- wr_x  in  9  write address.
- wr_data  in  DW  write pixel.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- pix_out  out  DW  front-bank pixel.
- pix_valid  out  1  one-clk100 strobe qualifying pix_out.
- bank_sel  out  1  index of the current front bank.
- drop_err  out  1  sticky; set by a write with wr_x >= LINE_W.

## Operation
- Edge detect: register mckr_q ← MCKR each cycle. A pixel tick is mckr_q==0 && MCKR==1.
- Top FSM, INIT:
  - Entered on reset.
  - Writes 0 to both banks, one address per cycle, for 2*LINE_W cycles.
  - wr_ready=0 and pix_valid=0 throughout.
  - Goes to RUN after the last address. Ticks and NXL_b are ignored in INIT.
- Top FSM, RUN: normal operation.
- Swap:
  - On a tick where NXL_b==0 and the NXL_b sampled on the previous tick was 1: bank_sel toggles and rd_x ← 0.
  - A write accepted before the swap cycle completes into the bank it targeted at acceptance.
- Read:
  - On a tick with HBLANK_b==1 and rd_x < LINE_W: pix_out ← front[rd_x] and pix_valid=1 on the next cycle. rd_x increments.
  - If BUFCLR_b==0 on that tick, front[rd_x] ← 0 on the cycle after the read.
  - When rd_x reaches LINE_W it saturates: no further reads, pix_valid stays 0 until the next swap.
  - A swap tick with HBLANK_b==1 reads address 0 of the new front bank.
- Write (RUN, LB_PRIORITY_EN absent):
  - wr_ready=1 continuously.
  - An accepted write with wr_x < LINE_W updates back[wr_x] at the end of the accept cycle.
  - wr_x >= LINE_W is accepted, discarded, and sets drop_err.
- Back-to-back writes to the same address: the last one wins.
- Read/clear ports and the write port always address different banks, so there is no contention.

## Timing
- Reset values:
  - pix_out=0, pix_valid=0, wr_ready=0, bank_sel=0, drop_err=0.
  - rd_x=0, mckr_q=0, previous NXL_b sample=1.
  - FSM=INIT.
- wr_ready first rises the cycle after INIT finishes, i.e. 2*LINE_W+1 cycles after rst_b release.
- Read latency: pix_valid asserts exactly 1 clk100 after the tick cycle, for 1 cycle.
- Clear lands 2 cycles after the tick. The next tick is ≥7 cycles later, so it cannot collide.
- Reset mid-operation: everything returns to reset values immediately and INIT reruns. No pending write is committed.

## Configuration
- LB_PRIORITY_EN defined (first-write-wins, for motion-object priority):
  - Write FSM IDLE→CMP.
  - An accepted write reads back[wr_x] in IDLE and moves to CMP with wr_ready=0.
  - In CMP, data is written only if the stored low 4 bits == 0 (transparent); otherwise it is dropped silently. Return to IDLE.
  - Sustained throughput: one write per 2 cycles.
  - The swap does not abort CMP; the compare-write completes to the originally targeted bank.
- LB_PRIORITY_EN undefined: last-write-wins, single-cycle writes, as described under Operation.

## Test plan
- Reset release → wr_ready low for 672 cycles, then high. Reads of both banks before any write return 0x00.
- Write x=5 data 0xA3, then swap, then 6 ticks with HBLANK_b=1 → sixth pix_valid carries 0xA3; the other five carry 0x00.
- Same as above with BUFCLR_b=0, then two more swaps and a readout → x=5 returns 0x00.
- Write x=400 → no bank change, drop_err=1 and stays set until reset.
- LB_PRIORITY_EN: write x=9 0x12, then x=9 0x34 → readout 0x12. wr_ready low on the cycle after each accept.
- Assert rst_b=0 mid-line after 100 ticks → outputs at reset values, bank_sel=0, INIT reruns, prior data reads back 0x00.
